// File: rtl/dispatch_ctrl_pkg.sv
// Shared constants for the dispatch controller: queue depths, credit widths
// and the per-slot instruction class encoding.
package dispatch_ctrl_pkg;

  localparam int SLOTS     = 4;
  localparam int ALU_DEPTH = 16;
  localparam int MEM_DEPTH = 8;
  localparam int BR_DEPTH  = 4;
  localparam int ROB_DEPTH = 32;

  // Each credit counter must represent 0..depth inclusive.
  localparam int ALU_W = 5;
  localparam int MEM_W = 4;
  localparam int BR_W  = 3;
  localparam int ROB_W = 6;

  // Per-cycle grant count width (0..SLOTS).
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    CLS_ALU = 2'b00,
    CLS_MEM = 2'b01,
    CLS_BR  = 2'b10,
    CLS_NOP = 2'b11
  } cls_e;

endpackage

// File: rtl/dispatch_ctrl_credit_ctr.sv
// Saturating free-entry credit counter: subtracts this cycle's grants, adds
// releases, clamps to [0, DEPTH]; reset or restore reloads DEPTH.
module credit_ctr #(
  parameter int DEPTH = 16,
  parameter int W     = 5,
  parameter int TW    = 3,
  parameter int RW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_restore,
  input  logic [TW-1:0] i_take,
  input  logic [RW-1:0] i_rel,
  output logic [W-1:0]  o_cred
);

  localparam int SW = W + 2;

  logic [W-1:0]         r_cred;
  logic signed [SW-1:0] w_sum;
  logic [W-1:0]         w_next;

  // Net the update at a wider signed width so an over-release saturates
  // instead of wrapping.
  always_comb begin
    w_sum  = $signed({2'b00, r_cred}) + $signed(SW'(i_rel)) - $signed(SW'(i_take));
    w_next = w_sum[W-1:0];
    if (w_sum[SW-1]) begin
      w_next = '0;
    end else if (w_sum > $signed(SW'(DEPTH))) begin
      w_next = W'(DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_restore) begin
      r_cred <= W'(DEPTH);
    end else begin
      r_cred <= w_next;
    end
  end

  assign o_cred = r_cred;

endmodule

// File: rtl/dispatch_ctrl.sv
// In-order 4-wide dispatch controller: grants DS slots against per-class
// issue-queue credits and ROB credits, holding DS until the bundle drains.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic [SLOTS-1:0]  i_ds_valid,
  input  logic [2*SLOTS-1:0] i_ds_cls,
  input  logic [1:0]        i_alu_rel,
  input  logic              i_mem_rel,
  input  logic              i_br_rel,
  input  logic [2:0]        i_rob_rel,
  output logic [SLOTS-1:0]  o_disp_en,
  output logic              o_disp_stall,
  output logic [ALU_W-1:0]  o_alu_cred,
  output logic [MEM_W-1:0]  o_mem_cred,
  output logic [BR_W-1:0]   o_br_cred,
  output logic [ROB_W-1:0]  o_rob_cred,
  output logic [15:0]       o_stall_cnt
);

  logic [SLOTS-1:0] r_sent;
  logic [15:0]      r_stall_cnt;

  logic [ALU_W-1:0] w_alu_cred;
  logic [MEM_W-1:0] w_mem_cred;
  logic [BR_W-1:0]  w_br_cred;
  logic [ROB_W-1:0] w_rob_cred;

  logic w_kill;
  logic [SLOTS-1:0] w_pend;
  logic [SLOTS-1:0] w_ok;
  logic [SLOTS-1:0] w_grant;
  logic [SLOTS:0]   w_blk;

  // Running grant counts along the prefix chain; entry gi is the demand of
  // slots granted before slot gi.
  logic [SLOTS:0][CNT_W-1:0] w_n_alu;
  logic [SLOTS:0][CNT_W-1:0] w_n_mem;
  logic [SLOTS:0][CNT_W-1:0] w_n_br;
  logic [SLOTS:0][CNT_W-1:0] w_n_rob;

  assign w_kill     = rst | i_flush;
  assign w_blk[0]   = 1'b0;
  assign w_n_alu[0] = '0;
  assign w_n_mem[0] = '0;
  assign w_n_br[0]  = '0;
  assign w_n_rob[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      cls_e w_cls;
      logic w_cls_ok;

      assign w_cls = cls_e'(i_ds_cls[2*gi+1:2*gi]);

      always_comb begin
        case (w_cls)
          CLS_ALU: w_cls_ok = w_alu_cred > {2'b00, w_n_alu[gi]};
          CLS_MEM: w_cls_ok = w_mem_cred > {1'b0, w_n_mem[gi]};
          CLS_BR:  w_cls_ok = w_br_cred > w_n_br[gi];
          default: w_cls_ok = 1'b1;
        endcase
      end

      assign w_pend[gi]  = i_ds_valid[gi] & ~r_sent[gi];
      assign w_ok[gi]    = w_cls_ok & (w_rob_cred > {3'b000, w_n_rob[gi]});
      assign w_grant[gi] = w_pend[gi] & ~w_blk[gi] & w_ok[gi];
      // A pending slot that cannot go blocks everything younger this cycle.
      assign w_blk[gi+1] = w_blk[gi] | (w_pend[gi] & ~w_ok[gi]);

      assign w_n_alu[gi+1] = w_n_alu[gi] + {2'b00, w_grant[gi] & (w_cls == CLS_ALU)};
      assign w_n_mem[gi+1] = w_n_mem[gi] + {2'b00, w_grant[gi] & (w_cls == CLS_MEM)};
      assign w_n_br[gi+1]  = w_n_br[gi]  + {2'b00, w_grant[gi] & (w_cls == CLS_BR)};
      assign w_n_rob[gi+1] = w_n_rob[gi] + {2'b00, w_grant[gi]};
    end
  endgenerate

  assign o_disp_en    = w_kill ? '0 : w_grant;
  assign o_disp_stall = ~w_kill & (|(i_ds_valid & ~(r_sent | w_grant)));

  // Reset and flush both reload the counters, so grant counts need no gating.
  credit_ctr #(.DEPTH(ALU_DEPTH), .W(ALU_W), .TW(CNT_W), .RW(2)) u_alu_ctr (
    .clk(clk), .rst(rst), .i_restore(i_flush),
    .i_take(w_n_alu[SLOTS]), .i_rel(i_alu_rel), .o_cred(w_alu_cred)
  );

  credit_ctr #(.DEPTH(MEM_DEPTH), .W(MEM_W), .TW(CNT_W), .RW(1)) u_mem_ctr (
    .clk(clk), .rst(rst), .i_restore(i_flush),
    .i_take(w_n_mem[SLOTS]), .i_rel(i_mem_rel), .o_cred(w_mem_cred)
  );

  credit_ctr #(.DEPTH(BR_DEPTH), .W(BR_W), .TW(CNT_W), .RW(1)) u_br_ctr (
    .clk(clk), .rst(rst), .i_restore(i_flush),
    .i_take(w_n_br[SLOTS]), .i_rel(i_br_rel), .o_cred(w_br_cred)
  );

  credit_ctr #(.DEPTH(ROB_DEPTH), .W(ROB_W), .TW(CNT_W), .RW(3)) u_rob_ctr (
    .clk(clk), .rst(rst), .i_restore(i_flush),
    .i_take(w_n_rob[SLOTS]), .i_rel(i_rob_rel), .o_cred(w_rob_cred)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sent      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_sent <= o_disp_stall ? (r_sent | o_disp_en) : '0;
      if (o_disp_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign o_alu_cred  = w_alu_cred;
  assign o_mem_cred  = w_mem_cred;
  assign o_br_cred   = w_br_cred;
  assign o_rob_cred  = w_rob_cred;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: directed vector table for the documented corner
// cases, then constrained-random bundles against a slot-walking reference.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush;
  logic [3:0]  i_ds_valid;
  logic [7:0]  i_ds_cls;
  logic [1:0]  i_alu_rel;
  logic        i_mem_rel;
  logic        i_br_rel;
  logic [2:0]  i_rob_rel;
  logic [3:0]  o_disp_en;
  logic        o_disp_stall;
  logic [4:0]  o_alu_cred;
  logic [3:0]  o_mem_cred;
  logic [2:0]  o_br_cred;
  logic [5:0]  o_rob_cred;
  logic [15:0] o_stall_cnt;

  always #5 clk = ~clk;

  dispatch_ctrl dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .i_ds_valid(i_ds_valid), .i_ds_cls(i_ds_cls),
    .i_alu_rel(i_alu_rel), .i_mem_rel(i_mem_rel), .i_br_rel(i_br_rel), .i_rob_rel(i_rob_rel),
    .o_disp_en(o_disp_en), .o_disp_stall(o_disp_stall),
    .o_alu_cred(o_alu_cred), .o_mem_cred(o_mem_cred), .o_br_cred(o_br_cred),
    .o_rob_cred(o_rob_cred), .o_stall_cnt(o_stall_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: free entries per queue (ALU, MEM, BR), ROB, stall count.
  int         m_cred[3];
  int         m_depth[3] = '{16, 8, 4};
  int         m_rob;
  int         m_scnt;
  logic [3:0] m_sent;
  logic [3:0] m_en;
  logic       m_stall;

  typedef struct {
    logic       r;
    logic       f;
    logic [3:0] v;
    logic [7:0] cls;
    logic [1:0] ar;
    logic       mr;
    logic       br;
    logic [2:0] rr;
    logic [3:0] en;
    logic       st;
    int         alu;
    int         mem;
    int         brc;
    int         rob;
    int         scnt;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Walk slots oldest-first, granting while both credits cover the demand.
  task automatic model_eval();
    int used[3];
    int used_rob;
    bit blocked;
    int c;
    bit ok;
    used     = '{0, 0, 0};
    used_rob = 0;
    blocked  = 0;
    m_en     = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i_ds_valid[i] && !m_sent[i] && !blocked) begin
        c  = int'(i_ds_cls[2*i +: 2]);
        ok = (m_rob > used_rob);
        if (c != 3) ok = ok && (m_cred[c] > used[c]);
        if (ok) begin
          m_en[i] = 1'b1;
          used_rob++;
          if (c != 3) used[c]++;
        end else begin
          blocked = 1;
        end
      end
    end
    if (rst || i_flush) m_en = 4'b0000;
    m_stall = !(rst || i_flush) && ((i_ds_valid & ~(m_sent | m_en)) != 4'b0000);
  endtask

  task automatic model_update();
    int g;
    int rel;
    int tot;
    if (rst || i_flush) begin
      for (int k = 0; k < 3; k++) m_cred[k] = m_depth[k];
      m_rob  = 32;
      m_sent = 4'b0000;
      if (rst) m_scnt = 0;
    end else begin
      tot = 0;
      for (int k = 0; k < 3; k++) begin
        g = 0;
        for (int i = 0; i < 4; i++)
          if (m_en[i] && int'(i_ds_cls[2*i +: 2]) == k) g++;
        rel = (k == 0) ? int'(i_alu_rel) : (k == 1) ? int'(i_mem_rel) : int'(i_br_rel);
        m_cred[k] = m_cred[k] - g + rel;
        if (m_cred[k] > m_depth[k]) m_cred[k] = m_depth[k];
      end
      for (int i = 0; i < 4; i++) if (m_en[i]) tot++;
      m_rob = m_rob - tot + int'(i_rob_rel);
      if (m_rob > 32) m_rob = 32;
      if (m_stall) begin
        m_sent = m_sent | m_en;
        if (m_scnt < 65535) m_scnt++;
      end else begin
        m_sent = 4'b0000;
      end
    end
  endtask

  task automatic clock_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    // r f v cls ar mr br rr | en st | alu mem br rob scnt (before the edge)
    tbl[0]  = '{1'b0, 1'b0, 4'hF, 8'h00, 2'd0, 1'b0, 1'b0, 3'd0, 4'hF, 1'b0, 16, 8, 4, 32, 0};
    tbl[1]  = '{1'b0, 1'b0, 4'hF, 8'h55, 2'd0, 1'b0, 1'b0, 3'd0, 4'hF, 1'b0, 12, 8, 4, 28, 0};
    tbl[2]  = '{1'b0, 1'b0, 4'h7, 8'h55, 2'd0, 1'b0, 1'b0, 3'd4, 4'h7, 1'b0, 12, 4, 4, 24, 0};
    tbl[3]  = '{1'b0, 1'b0, 4'hF, 8'h05, 2'd0, 1'b1, 1'b0, 3'd0, 4'h1, 1'b1, 12, 1, 4, 25, 0};
    tbl[4]  = '{1'b0, 1'b0, 4'hF, 8'h05, 2'd0, 1'b0, 1'b0, 3'd0, 4'hE, 1'b0, 12, 1, 4, 24, 1};
    tbl[5]  = '{1'b0, 1'b0, 4'hA, 8'hAA, 2'd0, 1'b0, 1'b0, 3'd0, 4'hA, 1'b0, 10, 0, 4, 21, 1};
    tbl[6]  = '{1'b0, 1'b0, 4'hF, 8'hFF, 2'd0, 1'b0, 1'b0, 3'd0, 4'hF, 1'b0, 10, 0, 2, 19, 1};
    tbl[7]  = '{1'b0, 1'b0, 4'hF, 8'hFF, 2'd0, 1'b0, 1'b0, 3'd0, 4'hF, 1'b0, 10, 0, 2, 15, 1};
    tbl[8]  = '{1'b0, 1'b0, 4'hF, 8'hFF, 2'd0, 1'b0, 1'b0, 3'd0, 4'hF, 1'b0, 10, 0, 2, 11, 1};
    tbl[9]  = '{1'b0, 1'b0, 4'hF, 8'hFF, 2'd0, 1'b0, 1'b0, 3'd0, 4'hF, 1'b0, 10, 0, 2, 7, 1};
    tbl[10] = '{1'b0, 1'b0, 4'h1, 8'hFF, 2'd0, 1'b0, 1'b0, 3'd0, 4'h1, 1'b0, 10, 0, 2, 3, 1};
    tbl[11] = '{1'b0, 1'b0, 4'hF, 8'hFF, 2'd0, 1'b0, 1'b0, 3'd0, 4'h3, 1'b1, 10, 0, 2, 2, 1};
    tbl[12] = '{1'b0, 1'b0, 4'hF, 8'hFF, 2'd0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b1, 10, 0, 2, 0, 2};
    tbl[13] = '{1'b0, 1'b1, 4'hF, 8'hFF, 2'd0, 1'b0, 1'b0, 3'd3, 4'h0, 1'b0, 10, 0, 2, 0, 3};
    tbl[14] = '{1'b0, 1'b0, 4'h0, 8'h00, 2'd2, 1'b1, 1'b1, 3'd4, 4'h0, 1'b0, 16, 8, 4, 32, 3};
    tbl[15] = '{1'b0, 1'b0, 4'hF, 8'h00, 2'd0, 1'b0, 1'b0, 3'd0, 4'hF, 1'b0, 16, 8, 4, 32, 3};
    tbl[16] = '{1'b1, 1'b0, 4'hF, 8'h00, 2'd0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 12, 8, 4, 28, 3};
    tbl[17] = '{1'b0, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 16, 8, 4, 32, 0};

    rst = 1'b1; i_flush = 1'b0; i_ds_valid = 4'h0; i_ds_cls = 8'h00;
    i_alu_rel = 2'd0; i_mem_rel = 1'b0; i_br_rel = 1'b0; i_rob_rel = 3'd0;
    m_sent = 4'b0000; m_rob = 0; m_scnt = 0; m_cred = '{0, 0, 0};
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      #1;
      model_eval();
      chk("rst_en", int'(o_disp_en), 0);
      chk("rst_stall", int'(o_disp_stall), 0);
      clock_model();
    end

    for (int k = 0; k < 18; k++) begin
      rst = tbl[k].r; i_flush = tbl[k].f; i_ds_valid = tbl[k].v; i_ds_cls = tbl[k].cls;
      i_alu_rel = tbl[k].ar; i_mem_rel = tbl[k].mr; i_br_rel = tbl[k].br; i_rob_rel = tbl[k].rr;
      #1;
      model_eval();
      $display("vec %0d: rst=%b flush=%b valid=%b cls=%h en=%b stall=%b cred=%0d/%0d/%0d/%0d scnt=%0d",
               k, rst, i_flush, i_ds_valid, i_ds_cls, o_disp_en, o_disp_stall,
               o_alu_cred, o_mem_cred, o_br_cred, o_rob_cred, o_stall_cnt);
      chk($sformatf("tbl%0d_en", k), int'(o_disp_en), int'(tbl[k].en));
      chk($sformatf("tbl%0d_stall", k), int'(o_disp_stall), int'(tbl[k].st));
      chk($sformatf("tbl%0d_alu", k), int'(o_alu_cred), tbl[k].alu);
      chk($sformatf("tbl%0d_mem", k), int'(o_mem_cred), tbl[k].mem);
      chk($sformatf("tbl%0d_br", k), int'(o_br_cred), tbl[k].brc);
      chk($sformatf("tbl%0d_rob", k), int'(o_rob_cred), tbl[k].rob);
      chk($sformatf("tbl%0d_scnt", k), int'(o_stall_cnt), tbl[k].scnt);
      clock_model();
    end

    // Random bundles; DS holds its bundle while the reference says stalled.
    m_stall = 1'b0;
    for (int n = 0; n < 500; n++) begin
      rst     = ($urandom_range(0, 63) == 0);
      i_flush = ($urandom_range(0, 31) == 0);
      if (!m_stall) begin
        i_ds_valid = 4'($urandom);
        i_ds_cls   = 8'($urandom);
      end
      i_alu_rel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      i_mem_rel = ($urandom_range(0, 3) == 0);
      i_br_rel  = ($urandom_range(0, 3) == 0);
      i_rob_rel = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
      #1;
      model_eval();
      $display("rnd %0d: rst=%b flush=%b valid=%b cls=%h en=%b/%b stall=%b/%b cred=%0d/%0d/%0d/%0d scnt=%0d",
               n, rst, i_flush, i_ds_valid, i_ds_cls, o_disp_en, m_en, o_disp_stall, m_stall,
               o_alu_cred, o_mem_cred, o_br_cred, o_rob_cred, o_stall_cnt);
      chk("rnd_en", int'(o_disp_en), int'(m_en));
      chk("rnd_stall", int'(o_disp_stall), int'(m_stall));
      chk("rnd_alu", int'(o_alu_cred), m_cred[0]);
      chk("rnd_mem", int'(o_mem_cred), m_cred[1]);
      chk("rnd_br", int'(o_br_cred), m_cred[2]);
      chk("rnd_rob", int'(o_rob_cred), m_rob);
      chk("rnd_scnt", int'(o_stall_cnt), m_scnt);
      clock_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
